// File: rtl/agv_nav_pkg.sv
// Shared navigation definitions for the AGV route tracker.
// Includes direction codes, FSM state encoding, sensor constants and a saturating counter helper.
package agv_nav_pkg;

  localparam logic [1:0] DIR_STRAIGHT = 2'b00;
  localparam logic [1:0] DIR_RIGHT    = 2'b01;
  localparam logic [1:0] DIR_LEFT     = 2'b10;
  localparam logic [1:0] DIR_UTURN    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nav_state_e;

  // All three sensors on the line marks a junction node.
  localparam logic [2:0] LS_NODE = 3'b111;
  // No sensor on the line: the vehicle has left the track.
  localparam logic [2:0] LS_NONE = 3'b000;

  // Node count sticks at 255 rather than wrapping back to 0.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/agv_ls_debounce.sv
// One line-sensor bit: 2-flop synchroniser followed by a debounce filter.
// The filtered bit flips only after the synchronised bit has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles; any agreement clears the run count.
module agv_ls_debounce #(
  parameter int DEBOUNCE_CYCLES = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic filt_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q,  filt_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Next-state: synchroniser shift and mismatch run counter.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_out = filt_q;

endmodule

// File: rtl/agv_route_tracker.sv
// AGV route tracker: conditions the line sensors, detects junction nodes and
// steps through a route table of turn commands, one entry per node.
// Optional line-loss detection is built when AGV_ROUTE_TRACKER_LOST_LINE_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for start; route table writable
//   RUN   | following the route, one table entry consumed per node
//   DONE  | last node reached, vehicle halted, outputs held
module agv_route_tracker
  import agv_nav_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 2000,
  parameter int NODE_MIN_CYCLES   = 5000,
  parameter int NODE_CLEAR_CYCLES = 20000,
  parameter int ROUTE_DEPTH       = 64,
  parameter int LOST_CYCLES       = 500000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     raw_ls,
  input  logic                           rt_wr_en,
  input  logic [$clog2(ROUTE_DEPTH)-1:0] rt_wr_addr,
  input  logic [1:0]                     rt_wr_data,
  input  logic [7:0]                     route_len,
  input  logic                           start,
  output logic [2:0]                     ip_from_ls,
  output logic [7:0]                     current_node,
  output logic [1:0]                     directions,
  output logic                           stop_signal,
  output logic                           node_pulse,
  output logic                           busy
`ifdef AGV_ROUTE_TRACKER_LOST_LINE_EN
  , output logic                         lost_line
`endif
);

  localparam int AW    = $clog2(ROUTE_DEPTH);
  localparam int HIT_W = $clog2(NODE_MIN_CYCLES + 1);
  localparam int CLR_W = $clog2(NODE_CLEAR_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [2:0] ls_filt;

  for (genvar i = 0; i < 3; i++) begin : g_ls
    agv_ls_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .raw_in  (raw_ls[i]),
      .filt_out(ls_filt[i])
    );
  end

  logic             armed_q, armed_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             node_pulse_q, node_pulse_d;
  logic             hit_fire, clr_fire;

  logic [1:0] state_q, state_d;
  logic [7:0] cur_node_q, cur_node_d;
  logic [1:0] dir_q, dir_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;
  logic [7:0] len_q, len_d;
  logic [7:0] k_next;
  logic [1:0] rt_rd;
  logic       start_ok;

  logic [1:0] rt_mem [ROUTE_DEPTH];

`ifdef AGV_ROUTE_TRACKER_LOST_LINE_EN
  localparam int LOST_W = $clog2(LOST_CYCLES + 1);
  logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d;
  logic              lost_q, lost_d;
  logic              lost_fire;

  // Line-loss timer: consecutive all-off cycles while following the route.
  always_comb begin
    lost_fire  = (state_q == ST_RUN) && (ls_filt == LS_NONE) &&
                 (lost_cnt_q == LOST_W'(LOST_CYCLES - 1));
    lost_cnt_d = '0;
    if ((state_q == ST_RUN) && (ls_filt == LS_NONE) && !lost_fire) begin
      lost_cnt_d = lost_cnt_q + 1'b1;
    end
  end
`endif

  // Node detector: armed, it waits for a long-enough 111 run; once fired it
  // must see a long-enough non-111 run before it can fire again.
  always_comb begin
    hit_fire  = armed_q && (ls_filt == LS_NODE) &&
                (hit_cnt_q == HIT_W'(NODE_MIN_CYCLES - 1));
    clr_fire  = !armed_q && (ls_filt != LS_NODE) &&
                (clr_cnt_q == CLR_W'(NODE_CLEAR_CYCLES - 1));
    armed_d   = armed_q;
    hit_cnt_d = '0;
    clr_cnt_d = '0;
    if (armed_q) begin
      if (ls_filt == LS_NODE) begin
        if (hit_fire) armed_d = 1'b0;
        else          hit_cnt_d = hit_cnt_q + 1'b1;
      end
    end else begin
      if (ls_filt != LS_NODE) begin
        if (clr_fire) armed_d = 1'b1;
        else          clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
    node_pulse_d = hit_fire && (state_q == ST_RUN);
  end

  // Route FSM: node count, direction lookup and run/stop status.
  always_comb begin
    state_d    = state_q;
    cur_node_d = cur_node_q;
    dir_d      = dir_q;
    stop_d     = stop_q;
    busy_d     = busy_q;
    len_d      = len_q;
`ifdef AGV_ROUTE_TRACKER_LOST_LINE_EN
    lost_d     = lost_q;
`endif
    k_next   = sat_inc8(cur_node_q);
    // The entry for event k is (k-1) mod depth, i.e. the current count's low bits.
    rt_rd    = rt_mem[cur_node_q[AW-1:0]];
    start_ok = start && (route_len != 8'd0);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d    = ST_RUN;
          cur_node_d = 8'd0;
          dir_d      = DIR_STRAIGHT;
          stop_d     = 1'b0;
          busy_d     = 1'b1;
          len_d      = route_len;
`ifdef AGV_ROUTE_TRACKER_LOST_LINE_EN
          lost_d     = 1'b0;
`endif
        end
      end
      ST_RUN: begin
`ifdef AGV_ROUTE_TRACKER_LOST_LINE_EN
        if (lost_fire) begin
          state_d = ST_IDLE;
          stop_d  = 1'b1;
          busy_d  = 1'b0;
          lost_d  = 1'b1;
        end else
`endif
        if (hit_fire) begin
          cur_node_d = k_next;
          dir_d      = rt_rd;
          if (k_next == len_q) begin
            state_d = ST_DONE;
            stop_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        stop_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and detector registers, returned to their idle values on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q      <= 1'b1;
      hit_cnt_q    <= '0;
      clr_cnt_q    <= '0;
      node_pulse_q <= 1'b0;
      state_q      <= ST_IDLE;
      cur_node_q   <= 8'd0;
      dir_q        <= DIR_STRAIGHT;
      stop_q       <= 1'b1;
      busy_q       <= 1'b0;
      len_q        <= 8'd0;
`ifdef AGV_ROUTE_TRACKER_LOST_LINE_EN
      lost_cnt_q   <= '0;
      lost_q       <= 1'b0;
`endif
    end else begin
      armed_q      <= armed_d;
      hit_cnt_q    <= hit_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      node_pulse_q <= node_pulse_d;
      state_q      <= state_d;
      cur_node_q   <= cur_node_d;
      dir_q        <= dir_d;
      stop_q       <= stop_d;
      busy_q       <= busy_d;
      len_q        <= len_d;
`ifdef AGV_ROUTE_TRACKER_LOST_LINE_EN
      lost_cnt_q   <= lost_cnt_d;
      lost_q       <= lost_d;
`endif
    end
  end

  // Route table storage; only writable while idle, contents survive reset.
  always_ff @(posedge clk) begin
    if (rt_wr_en && (state_q == ST_IDLE)) begin
      rt_mem[rt_wr_addr] <= rt_wr_data;
    end
  end

  assign ip_from_ls   = ls_filt;
  assign current_node = cur_node_q;
  assign directions   = dir_q;
  assign stop_signal  = stop_q;
  assign node_pulse   = node_pulse_q;
  assign busy         = busy_q;
`ifdef AGV_ROUTE_TRACKER_LOST_LINE_EN
  assign lost_line    = lost_q;
`endif

endmodule

// File: doc/agv_route_tracker.md
Name: agv_route_tracker

Overview:
- Upstream stage of the AGV motor controller: conditions the raw 3-bit line-sensor vector and counts junction nodes crossed.
- Steps through a loaded route table of turn commands, one entry per node.
- Drives the motor controller's line-sensor, current-node, direction and stop inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 2000, consecutive stable cycles before a sensor bit is accepted (>=1).
- NODE_MIN_CYCLES, 5000, cycles filtered vector must read 3'b111 to register a node (>=1).
- NODE_CLEAR_CYCLES, 20000, cycles filtered vector must read non-111 to re-arm detection (>=1).
- ROUTE_DEPTH, 64, route table entries (power of two, <=256).
- LOST_CYCLES, 500000, cycles of 3'b000 before line-loss (LOST_LINE_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- raw_ls  in  3  unsynchronised sensor bits {left,centre,right}, 1 = line seen
- rt_wr_en  in  1  route table write strobe, honoured only in IDLE
- rt_wr_addr  in  clog2(ROUTE_DEPTH)  write address
- rt_wr_data  in  2  direction code: 00 straight, 01 right, 10 left, 11 180-degree turn
- route_len  in  8  number of nodes in route, sampled on start; 0 is illegal and ignored
- start  in  1  one-cycle pulse, begins route from IDLE or DONE
- ip_from_ls  out  3  debounced sensor vector
- current_node  out  8  count of nodes crossed since start
- directions  out  2  command for the node just reached
- stop_signal  out  1  high when the vehicle must halt
- node_pulse  out  1  one-cycle strobe per detected node
- busy  out  1  high in RUN

Behaviour:
- Reset (async): ip_from_ls=000, current_node=0, directions=00, stop_signal=1, node_pulse=0, busy=0, state=IDLE, detector armed, all counters 0. Route table contents not reset.
- Sync: raw_ls passes a 2-flop synchroniser per bit.
- Debounce per bit: counter clears whenever synchronised bit equals filtered bit. Filtered bit takes the new value on the edge where the mismatch has held DEBOUNCE_CYCLES consecutive cycles. Latency from a clean raw step to ip_from_ls = 2 + DEBOUNCE_CYCLES cycles. A glitch shorter than DEBOUNCE_CYCLES never reaches the output.
- Node detector, armed: hit counter counts cycles of ip_from_ls==111 and clears on any other value. node_pulse fires on the edge where the count reaches NODE_MIN_CYCLES, and the detector disarms. Disarmed: clear counter counts non-111 cycles and resets on 111. Detector re-arms when the count reaches NODE_CLEAR_CYCLES. The detector runs in all states; node_pulse is suppressed outside RUN.
- FSM IDLE -> RUN on start with route_len!=0: current_node=0, directions=00, stop_signal=0, busy=1, len register = route_len.
- RUN on node_pulse (event k = current_node+1):
  - current_node<=k and directions<=table[k-1], both on the same edge as node_pulse.
  - If k==len, then RUN -> DONE: stop_signal=1, busy=0, directions holds table[len-1].
- DONE -> RUN on start, same actions as from IDLE. DONE holds its outputs otherwise.
- Address wrap: table index is (k-1) mod ROUTE_DEPTH. current_node saturates at 255.
- start during RUN is ignored. rt_wr_en outside IDLE is ignored. start and rt_wr_en in the same IDLE cycle: write completes, and the run starts with the new data.
- Reset mid-route returns to IDLE immediately with the reset values above.

Optional Feature:
- Macro AGV_ROUTE_TRACKER_LOST_LINE_EN.
- With it defined:
  - Adds output lost_line (1 bit, reset 0).
  - In RUN, LOST_CYCLES consecutive cycles of ip_from_ls==000 set lost_line=1 and stop_signal=1, and the FSM moves to IDLE with busy=0.
  - lost_line clears on the next accepted start.
- Without it: no port and no counter; 000 has no special effect.

Decomposition:
- Package agv_nav_pkg:
  - direction codes DIR_STRAIGHT/RIGHT/LEFT/UTURN
  - state enum IDLE/RUN/DONE
  - sensor constant LS_NODE=3'b111
- Sub-module agv_ls_debounce: one bit with synchroniser and debounce counter, parameter DEBOUNCE_CYCLES, instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, NODE_MIN_CYCLES=3, NODE_CLEAR_CYCLES=5, ROUTE_DEPTH=8):
- raw_ls 010->110 held steady -> ip_from_ls becomes 110 exactly 6 cycles later. A 3-cycle glitch to 111 leaves ip_from_ls unchanged.
- Load table {01,00,10}, route_len=3, start, then three clean 111 bursts of 10 cycles separated by 010 -> node_pulse x3; current_node 1,2,3 with directions 01,00,10; after the third, stop_signal=1 and busy=0.
- Two 111 bursts separated by only 3 cycles of 010 -> a single node_pulse, because the detector is not re-armed.
- Reset asserted after node 1 of a 3-node route -> outputs return to their reset values at once; a fresh start restarts at current_node=0.
- route_len=10 with DEPTH=8 -> node 9 issues table[0]. start during RUN is ignored. A write while in RUN leaves the table unchanged on readback.
- With LOST_LINE_EN and LOST_CYCLES=20: in RUN, hold raw 000 -> lost_line=1 and stop_signal=1, and the FSM is in IDLE 20 cycles after ip_from_ls goes 000.
